ttt_turn_arbiter: RTL

TTT_TURN_ARBITER -- requirements
Module: ttt_turn_arbiter

---
 rtl/ttt_turn_arbiter_if.sv | 27 ++
 rtl/ttt_turn_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_arbiter_if.sv
// Move/turn handshake between the turn arbiter and the tic-tac-toe game core.
// master = request/result side (core + players), slave = arbiter.
interface ttt_turn_arbiter_if;
   logic       play;
   logic [3:0] player;
   logic       comp;
   logic [3:0] computer;
   logic [1:0] winner;
   logic       mv_valid;
   logic       mv_who;
   logic [3:0] mv_pos;
   logic [1:0] turn;
   logic       reject;
   logic       timeout;
   logic       done;
   logic [3:0] move_count;

   modport master (
      output play, player, comp, computer, winner,
      input  mv_valid, mv_who, mv_pos, turn, reject, timeout, done, move_count
   );

   modport slave (
      input  play, player, comp, computer, winner,
      output mv_valid, mv_who, mv_pos, turn, reject, timeout, done, move_count
   );
endinterface

// File: rtl/ttt_turn_arbiter.sv
// Alternating player/computer turn arbiter with occupancy tracking for tic-tac-toe.
// Optional per-turn forfeit timer enabled by defining TURN_TIMEOUT_EN.
//
// state  | meaning
// P_TURN | waiting for a player move request
// C_TURN | waiting for a computer move request
// ISSUE  | mv_valid strobe cycle for the accepted move
// CHECK  | sample winner / move_count, pick next turn or finish
// DONE   | game over, held until reset
module ttt_turn_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic               clock,
   input  logic               reset,
   ttt_turn_arbiter_if.slave  bus
);

   typedef enum logic [2:0] {
      P_TURN = 3'd0,
      C_TURN = 3'd1,
      ISSUE  = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  occ_q, occ_d;
   logic [3:0]  move_count_q, move_count_d;
   logic [3:0]  mv_pos_q, mv_pos_d;
   logic        mv_who_q, mv_who_d;
   logic        mv_valid_q, mv_valid_d;
   logic        reject_q, reject_d;

   logic        in_turn;
   logic        req_act;
   logic [3:0]  req_idx;
   logic [15:0] occ_ext;
   logic        legal;
   logic        tmo_hit;
   logic [1:0]  turn_o;
   logic        done_o;

   always_comb begin : req_decode
      in_turn = (state_q == P_TURN) || (state_q == C_TURN);
      req_act = 1'b0;
      req_idx = 4'd0;
      case (state_q)
         P_TURN: begin
            req_act = bus.play;
            req_idx = bus.player;
         end
         C_TURN: begin
            req_act = bus.comp;
            req_idx = bus.computer;
         end
         default: ;
      endcase
      // Zero-extended map lets indices 9..15 read as "free" but fail the range test.
      occ_ext = {7'd0, occ_q};
      legal   = req_act && (req_idx <= 4'd8) && !occ_ext[req_idx];
   end

`ifdef TURN_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TW-1:0] timer_q, timer_d;
   logic          timeout_q, timeout_d;

   assign tmo_hit = in_turn && !legal && (timer_q == TW'(TIMEOUT - 1));

   always_comb begin : timer_next
      timer_d   = '0;
      timeout_d = tmo_hit;
      if (in_turn && (state_d == state_q)) begin
         timer_d = timer_q + TW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign tmo_hit     = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= P_TURN;
         occ_q        <= 9'd0;
         move_count_q <= 4'd0;
         mv_pos_q     <= 4'd0;
         mv_who_q     <= 1'b0;
         mv_valid_q   <= 1'b0;
         reject_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         move_count_q <= move_count_d;
         mv_pos_q     <= mv_pos_d;
         mv_who_q     <= mv_who_d;
         mv_valid_q   <= mv_valid_d;
         reject_q     <= reject_d;
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         P_TURN: begin
            if (legal)        state_d = ISSUE;
            else if (tmo_hit) state_d = C_TURN;
         end
         C_TURN: begin
            if (legal)        state_d = ISSUE;
            else if (tmo_hit) state_d = P_TURN;
         end
         ISSUE: state_d = CHECK;
         CHECK: begin
            // The side that just moved is in mv_who_q; the other side goes next.
            if ((bus.winner != 2'b00) || (move_count_q == 4'd9)) state_d = DONE;
            else if (mv_who_q)                                   state_d = P_TURN;
            else                                                 state_d = C_TURN;
         end
         DONE:    state_d = DONE;
         default: state_d = P_TURN;
      endcase
   end

   always_comb begin : fsm_out
      mv_valid_d   = legal;
      reject_d     = req_act && !legal;
      mv_who_d     = mv_who_q;
      mv_pos_d     = mv_pos_q;
      occ_d        = occ_q;
      move_count_d = move_count_q;
      if (legal) begin
         mv_who_d = (state_q == C_TURN);
         mv_pos_d = req_idx;
         occ_d    = occ_q | (9'd1 << req_idx);
         if (move_count_q != 4'd9) begin
            move_count_d = move_count_q + 4'd1;
         end
      end

      turn_o = 2'b00;
      case (state_q)
         P_TURN:  turn_o = 2'b01;
         C_TURN:  turn_o = 2'b10;
         default: turn_o = 2'b00;
      endcase
      done_o = (state_q == DONE);
   end

   assign bus.mv_valid   = mv_valid_q;
   assign bus.mv_who     = mv_who_q;
   assign bus.mv_pos     = mv_pos_q;
   assign bus.reject     = reject_q;
   assign bus.move_count = move_count_q;
   assign bus.turn       = turn_o;
   assign bus.done       = done_o;

endmodule
